// File: rtl/feedback_pkg.sv
// Shared definitions for the feedback frame decoder and the operate-data verifier:
// byte tags, machine-number field, status bit positions and decoder states.
package feedback_pkg;

    localparam logic [1:0] TAG_TARGET  = 2'b11;
    localparam logic [1:0] TAG_STATUS  = 2'b01;
    localparam logic [1:0] TAG_OPERATE = 2'b10;
    localparam logic [1:0] TAG_ILLEGAL = 2'b00;

    localparam int MACHINE_MSB = 6;
    localparam int MACHINE_LSB = 2;

    localparam int ST_IN_FRONT   = 2;
    localparam int ST_HAS_ITEM   = 3;
    localparam int ST_TGT_ITEM   = 4;
    localparam int ST_TGT_PROC   = 5;

    // Field order mirrors status bits [5:2] so a straight slice cast fills it.
    typedef struct packed {
        logic tgt_processing;
        logic tgt_has_item;
        logic has_item;
        logic in_front;
    } status_flags_t;

    typedef enum logic {
        S_IDLE        = 1'b0,
        S_WAIT_STATUS = 1'b1
    } fb_state_t;

    function automatic logic [MACHINE_MSB-MACHINE_LSB:0] machine_of(input logic [7:0] b);
        return b[MACHINE_MSB:MACHINE_LSB];
    endfunction

endpackage

// File: rtl/feedback_timeout_timer.sv
// Counts cycles spent waiting for a status byte; holds at the last count and
// flags expiry there until cleared.
module feedback_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST)) begin
            count_d = count_q + TW'(1);
        end
    end

    assign expire = enable && (count_q == LAST);

    // NOTE: state registers use non-blocking assignments only; reset is synchronous here.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/feedback_frame_decoder.sv
// Pairs a target-machine byte with the following status byte and commits both.
// Optional build macro FEEDBACK_PARITY_EN enables even parity on bit 7 of every byte.
module feedback_frame_decoder
    import feedback_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int ERR_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       target_machine,
    output logic             in_front_of_target,
    output logic             has_item_in_hand,
    output logic             target_has_item,
    output logic             target_is_processing,
    output logic             feedback_valid,
    output logic             busy,
    output logic [ERR_W-1:0] err_count
);

    fb_state_t        state_q, state_d;
    logic [7:0]       pending_q, pending_d;
    logic [7:0]       target_q, target_d;
    status_flags_t    flags_q, flags_d;
    logic             valid_q, valid_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic parity_ok;
`ifdef FEEDBACK_PARITY_EN
    assign parity_ok = ~(^rx_data);
`else
    logic unused_parity_bit;
    assign unused_parity_bit = rx_data[7];
    assign parity_ok         = 1'b1;
`endif

    logic byte_ok, is_target, is_status, is_illegal, parity_err;
    assign byte_ok    = rx_valid && parity_ok;
    assign parity_err = rx_valid && !parity_ok;
    assign is_target  = byte_ok && (rx_data[1:0] == TAG_TARGET);
    assign is_status  = byte_ok && (rx_data[1:0] == TAG_STATUS);
    assign is_illegal = byte_ok && (rx_data[1:0] == TAG_ILLEGAL);

    logic timer_clr, timer_expire, err_inc;

    feedback_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clr),
        .enable (state_q == S_WAIT_STATUS),
        .expire (timer_expire)
    );

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        target_d  = target_q;
        flags_d   = flags_q;
        valid_d   = 1'b0;
        timer_clr = 1'b0;
        err_inc   = is_illegal || parity_err;

        unique case (state_q)
            S_IDLE: begin
                if (is_target) begin
                    pending_d = rx_data;
                    timer_clr = 1'b1;
                    state_d   = S_WAIT_STATUS;
                end else if (is_status) begin
                    err_inc = 1'b1;
                end
            end
            S_WAIT_STATUS: begin
                if (is_target) begin
                    pending_d = rx_data;
                    timer_clr = 1'b1;
                end else if (is_status) begin
                    target_d = pending_q;
                    flags_d  = status_flags_t'(rx_data[ST_TGT_PROC:ST_IN_FRONT]);
                    valid_d  = 1'b1;
                    state_d  = S_IDLE;
                end else if (!rx_valid && timer_expire) begin
                    // Any byte in the expiry cycle, even an ignored one, defers the timeout.
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        err_d = (err_inc && (err_q != '1)) ? err_q + ERR_W'(1) : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= 8'h00;
            target_q  <= 8'h00;
            flags_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            target_q  <= target_d;
            flags_q   <= flags_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign target_machine       = target_q;
    assign in_front_of_target   = flags_q.in_front;
    assign has_item_in_hand     = flags_q.has_item;
    assign target_has_item      = flags_q.tgt_has_item;
    assign target_is_processing = flags_q.tgt_processing;
    assign feedback_valid       = valid_q;
    assign busy                 = (state_q == S_WAIT_STATUS);
    assign err_count            = err_q;

endmodule

// File: tb/tb_feedback_frame_decoder.sv
// Scoreboard bench for feedback_frame_decoder: directed frames, then random byte
// streams checked against a frame-level reference model.
module tb_feedback_frame_decoder;

    localparam int T  = 12;
    localparam int EW = 4;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [7:0]    target_machine;
    logic          in_front_of_target, has_item_in_hand, target_has_item, target_is_processing;
    logic          feedback_valid, busy;
    logic [EW-1:0] err_count;

    always #5 clk = ~clk;

    feedback_frame_decoder #(.TIMEOUT_CYCLES(T), .ERR_W(EW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rx_data              (rx_data),
        .rx_valid             (rx_valid),
        .target_machine       (target_machine),
        .in_front_of_target   (in_front_of_target),
        .has_item_in_hand     (has_item_in_hand),
        .target_has_item      (target_has_item),
        .target_is_processing (target_is_processing),
        .feedback_valid       (feedback_valid),
        .busy                 (busy),
        .err_count            (err_count)
    );

    typedef struct {
        logic [7:0]    tgt;
        logic [3:0]    flags;
        logic          fv;
        logic          busy;
        logic [EW-1:0] err;
    } cyc_t;

    typedef struct {
        logic [7:0] tgt;
        logic [3:0] flags;
    } commit_t;

    cyc_t    cyc_q[$];
    commit_t com_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is "open" from the edge its target byte lands;
    // it times out at the first byte-free edge at least T edges later.
    int         edge_n  = 0;
    bit         m_open  = 0;
    logic [7:0] m_pend  = 8'h00;
    int         m_tedge = 0;
    logic [7:0] m_tgt   = 8'h00;
    logic [3:0] m_flags = 4'h0;
    int         m_err   = 0;

    function automatic bit parity_bad(input logic [7:0] b);
`ifdef FEEDBACK_PARITY_EN
        return ^b;
`else
        return (b === 8'hxx);
`endif
    endfunction

    task automatic model_step(input bit r, input bit v, input logic [7:0] d);
        bit   fv;
        bit   err_hit;
        cyc_t e;
        edge_n++;
        fv      = 0;
        err_hit = 0;
        if (r) begin
            m_open = 0; m_pend = 8'h00; m_tgt = 8'h00; m_flags = 4'h0; m_err = 0;
        end else if (v) begin
            if (parity_bad(d)) err_hit = 1;
            else if (d[1:0] == 2'b11) begin
                m_open = 1; m_pend = d; m_tedge = edge_n;
            end else if (d[1:0] == 2'b01) begin
                if (m_open) begin
                    commit_t c;
                    m_tgt = m_pend; m_flags = d[5:2]; m_open = 0; fv = 1;
                    c.tgt = m_tgt; c.flags = m_flags;
                    com_q.push_back(c);
                end else err_hit = 1;
            end else if (d[1:0] == 2'b00) err_hit = 1;
        end else if (m_open && (edge_n - m_tedge >= T)) begin
            m_open  = 0;
            err_hit = 1;
        end
        if (err_hit && m_err < ERR_MAX) m_err++;
        e.tgt = m_tgt; e.flags = m_flags; e.fv = fv; e.busy = m_open; e.err = EW'(m_err);
        cyc_q.push_back(e);
    endtask

    task automatic drive(input bit r, input bit v, input logic [7:0] d);
        @(negedge clk);
        #1;
        rst = r; rx_valid = v; rx_data = d;
        model_step(r, v, d);
    endtask

    task automatic send(input logic [7:0] d);
        drive(0, 1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 8'($urandom));
    endtask

    task automatic do_reset();
        drive(1, 0, 8'h00);
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] b;
        int         k;
        b = 8'($urandom);
        k = $urandom_range(0, 9);
        if (k < 4)      b[1:0] = 2'b11;
        else if (k < 8) b[1:0] = 2'b01;
        else if (k < 9) b[1:0] = 2'b10;
        else            b[1:0] = 2'b00;
`ifdef FEEDBACK_PARITY_EN
        if ($urandom_range(0, 3) != 0) b[7] = ^b[6:0];
`endif
        return b;
    endfunction

    // Monitor: checks every cycle against the model, and matches each commit pulse
    // against the commit scoreboard.
    always @(negedge clk) begin
        if (cyc_q.size() > 0) begin
            cyc_t e;
            e = cyc_q.pop_front();
            check("feedback_valid", feedback_valid, e.fv);
            check("busy", busy, e.busy);
            check("err_count", err_count, e.err);
            check("target_machine", target_machine, e.tgt);
            check("flags", {target_is_processing, target_has_item, has_item_in_hand, in_front_of_target}, e.flags);
            if (feedback_valid === 1'b1) begin
                if (com_q.size() == 0) begin
                    check("commit_expected", 32'd0, 32'd1);
                end else begin
                    commit_t c;
                    c = com_q.pop_front();
                    check("commit_target", target_machine, c.tgt);
                    check("commit_flags", {target_is_processing, target_has_item, has_item_in_hand, in_front_of_target}, c.flags);
                end
            end
        end
    end

    initial begin
        do_reset();
        do_reset();
        idle(1);
        check("reset_err", err_count, 0);
        check("reset_busy", busy, 0);
        check("reset_target", target_machine, 8'h00);

`ifndef FEEDBACK_PARITY_EN
        send(8'h27); idle(3); send(8'h0D); idle(1);
        check("basic_target", target_machine, 8'h27);
        check("basic_flags", {target_is_processing, target_has_item, has_item_in_hand, in_front_of_target}, 4'b0011);
        check("basic_valid_hi", feedback_valid, 1);
        idle(1);
        check("basic_valid_lo", feedback_valid, 0);
`else
        do_reset();
        send(8'h27); send(8'h0D); idle(1);
        check("parity_err", err_count, 1);
        check("parity_busy", busy, 1);
        send(8'h8D); idle(1);
        check("parity_commit_valid", feedback_valid, 1);
        check("parity_commit_flags", {target_is_processing, target_has_item, has_item_in_hand, in_front_of_target}, 4'b0011);
`endif

        do_reset();
        send(8'h3D); idle(1);
        check("orphan_err", err_count, 1);
        check("orphan_valid", feedback_valid, 0);
        check("orphan_flags", {target_is_processing, target_has_item, has_item_in_hand, in_front_of_target}, 4'b0000);

        do_reset();
        send(8'h27);
        for (int k = 1; k <= T; k++) begin
            idle(1);
            check("timeout_busy_hi", busy, 1);
        end
        idle(1);
        check("timeout_busy_lo", busy, 0);
        check("timeout_err", err_count, 1);
        send(8'h0D); idle(1);
        check("late_orphan_err", err_count, 2);

        do_reset();
        send(8'h27); send(8'h3F); send(8'h0A); send(8'h11); idle(1);
        check("overwrite_target", target_machine, 8'h3F);
        check("overwrite_tgt_item", target_has_item, 1);
        check("overwrite_err", err_count, 0);

        do_reset();
        send(8'h27); do_reset(); send(8'h0D); idle(1);
        check("midreset_err", err_count, 1);
        check("midreset_target", target_machine, 8'h00);
        check("midreset_flags", {target_is_processing, target_has_item, has_item_in_hand, in_front_of_target}, 4'b0000);

        do_reset();
        for (int i = 0; i < ERR_MAX + 5; i++) send(8'h00);
        idle(1);
        check("err_saturate", err_count, ERR_MAX);

        for (int blk = 0; blk < 120; blk++) begin
            bit sparse;
            sparse = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < 25; i++) begin
                bit v, r;
                v = sparse ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 6);
                r = ($urandom_range(0, 149) == 0);
                drive(r, v, rand_byte());
            end
        end

        idle(3);
        @(negedge clk);
        #1;
        check("commit_drain", com_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
